// File: rtl/counter_access_ctrl.sv
// Per-counter CPU access sequencer for an 8254-style timer: decodes control words,
// assembles byte-wise count writes and serves byte-wise reads from live or latched count.
module counter_access_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cw_wr,
    input  logic [7:0]       cw,
    input  logic             wr,
    input  logic             rd,
    input  logic [7:0]       data_in,
    input  logic [WIDTH-1:0] current_count,
    input  logic             ce_load_ack,
    output logic [WIDTH-1:0] count_reg,
    output logic             count_load,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic [1:0]       rw_mode,
    output logic [2:0]       mode,
    output logic             bcd,
    output logic             latched,
    output logic             null_count,
    output logic             programmed
);

    logic [WIDTH-1:0] count_reg_q, count_reg_d;
    logic             count_load_q, count_load_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic [1:0]       rw_mode_q, rw_mode_d;
    logic [2:0]       mode_q, mode_d;
    logic             bcd_q, bcd_d;
    logic             latched_q, latched_d;
    logic             null_count_q, null_count_d;
    logic             programmed_q, programmed_d;
    logic [WIDTH-1:0] snapshot_q, snapshot_d;
    logic             read_ff_q, read_ff_d;
    logic             write_ff_q, write_ff_d;

    logic             is_latch_cmd;
    logic             is_mode_word;
    logic             wr_accept;
    logic             rd_accept;
    logic [WIDTH-1:0] rd_source;
    logic             rd_high;
    logic             rd_last;
    logic             cw_unused;

    assign cw_unused = ^cw[7:6];

    // Request decode: control words outrank data accesses; a simultaneous rd+wr is dropped.
    always_comb begin
        is_latch_cmd = cw_wr && (cw[5:4] == 2'b00);
        is_mode_word = cw_wr && (cw[5:4] != 2'b00);
        wr_accept    = programmed_q && !cw_wr && wr && !rd;
        rd_accept    = programmed_q && !cw_wr && rd && !wr;
        rd_source    = latched_q ? snapshot_q : current_count;
        rd_high      = (rw_mode_q == 2'b10) || ((rw_mode_q == 2'b11) && read_ff_q);
        rd_last      = (rw_mode_q != 2'b11) || read_ff_q;
    end

    always_comb begin
        count_reg_d  = count_reg_q;
        count_load_d = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        rw_mode_d    = rw_mode_q;
        mode_d       = mode_q;
        bcd_d        = bcd_q;
        latched_d    = latched_q;
        null_count_d = null_count_q;
        programmed_d = programmed_q;
        snapshot_d   = snapshot_q;
        read_ff_d    = read_ff_q;
        write_ff_d   = write_ff_q;

        if (ce_load_ack) begin
            null_count_d = 1'b0;
        end

        if (is_latch_cmd) begin
            if (!latched_q) begin
                snapshot_d = current_count;
                latched_d  = 1'b1;
            end
        end else if (is_mode_word) begin
            rw_mode_d    = cw[5:4];
            mode_d       = cw[3:1];
            bcd_d        = cw[0];
            programmed_d = 1'b1;
            read_ff_d    = 1'b0;
            write_ff_d   = 1'b0;
            latched_d    = 1'b0;
            null_count_d = 1'b1;
        end else if (wr_accept) begin
            null_count_d = 1'b1;
            case (rw_mode_q)
                2'b01: begin
                    count_reg_d  = {8'h00, data_in};
                    count_load_d = 1'b1;
                end
                2'b10: begin
                    count_reg_d  = {data_in, 8'h00};
                    count_load_d = 1'b1;
                end
                2'b11: begin
                    if (!write_ff_q) begin
                        count_reg_d[7:0] = data_in;
                        write_ff_d       = 1'b1;
                    end else begin
                        count_reg_d[WIDTH-1:8] = data_in;
                        write_ff_d             = 1'b0;
                        count_load_d           = 1'b1;
                    end
                end
                default: begin
                    count_reg_d = count_reg_q;
                end
            endcase
        end else if (rd_accept) begin
            data_out_d   = rd_high ? rd_source[WIDTH-1:8] : rd_source[7:0];
            data_valid_d = 1'b1;
            if (rw_mode_q == 2'b11) begin
                read_ff_d = !read_ff_q;
            end
            // The latch holds until the last byte of the read sequence has gone out.
            if (rd_last) begin
                latched_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg_q  <= '0;
            count_load_q <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            rw_mode_q    <= 2'b01;
            mode_q       <= 3'b000;
            bcd_q        <= 1'b0;
            latched_q    <= 1'b0;
            null_count_q <= 1'b0;
            programmed_q <= 1'b0;
            snapshot_q   <= '0;
            read_ff_q    <= 1'b0;
            write_ff_q   <= 1'b0;
        end else begin
            count_reg_q  <= count_reg_d;
            count_load_q <= count_load_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            rw_mode_q    <= rw_mode_d;
            mode_q       <= mode_d;
            bcd_q        <= bcd_d;
            latched_q    <= latched_d;
            null_count_q <= null_count_d;
            programmed_q <= programmed_d;
            snapshot_q   <= snapshot_d;
            read_ff_q    <= read_ff_d;
            write_ff_q   <= write_ff_d;
        end
    end

    assign count_reg  = count_reg_q;
    assign count_load = count_load_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign rw_mode    = rw_mode_q;
    assign mode       = mode_q;
    assign bcd        = bcd_q;
    assign latched    = latched_q;
    assign null_count = null_count_q;
    assign programmed = programmed_q;

endmodule

// File: tb/tb_counter_access_ctrl.sv
// Scoreboard bench for counter_access_ctrl: directed scenarios followed by random traffic,
// checked against a byte-level reference model of the 8254 counter access rules.
module tb_counter_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cw_wr;
    logic [7:0]  cw;
    logic        wr;
    logic        rd;
    logic [7:0]  data_in;
    logic [15:0] current_count;
    logic        ce_load_ack;
    logic [15:0] count_reg;
    logic        count_load;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [1:0]  rw_mode;
    logic [2:0]  mode;
    logic        bcd;
    logic        latched;
    logic        null_count;
    logic        programmed;

    counter_access_ctrl #(.WIDTH(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cw_wr         (cw_wr),
        .cw            (cw),
        .wr            (wr),
        .rd            (rd),
        .data_in       (data_in),
        .current_count (current_count),
        .ce_load_ack   (ce_load_ack),
        .count_reg     (count_reg),
        .count_load    (count_load),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .rw_mode       (rw_mode),
        .mode          (mode),
        .bcd           (bcd),
        .latched       (latched),
        .null_count    (null_count),
        .programmed    (programmed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_count = 0;
    int check_count = 0;

    // Expected read bytes and completed count values, in issue order.
    logic [7:0]  read_q[$];
    logic [15:0] load_q[$];

    // Reference model of the counter's programming and access state.
    bit          m_prog;
    logic [1:0]  m_rw;
    logic [2:0]  m_mode;
    bit          m_bcd;
    bit          m_latched;
    logic [15:0] m_snap;
    int          m_rd_bytes_done;
    int          m_wr_bytes_done;
    logic [15:0] m_count;
    bit          m_null;
    logic [7:0]  m_last_out;
    bit          m_load_now;
    bit          m_valid_now;

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_prog = 0; m_rw = 2'b01; m_mode = 3'd0; m_bcd = 0;
        m_latched = 0; m_snap = 16'h0; m_rd_bytes_done = 0; m_wr_bytes_done = 0;
        m_count = 16'h0; m_null = 0; m_last_out = 8'h00;
        m_load_now = 0; m_valid_now = 0;
        read_q.delete();
        load_q.delete();
    endtask

    // Bytes in a full access for the current RW mode: one for LSB/MSB only, two for LSB-then-MSB.
    function automatic int seqLen(input logic [1:0] rw);
        return (rw == 2'b11) ? 2 : 1;
    endfunction

    // Drive one cycle of bus activity, update the reference model, and advance one clock.
    task automatic applyStimulus(input bit i_cw, input logic [7:0] i_cwv, input bit i_wr,
                                 input bit i_rd, input logic [7:0] i_din,
                                 input logic [15:0] i_count, input bit i_ack);
        bit          next_load;
        bit          next_valid;
        bit          want_high;
        logic [15:0] src;
        logic [7:0]  b;
        cw_wr = i_cw; cw = i_cwv; wr = i_wr; rd = i_rd;
        data_in = i_din; current_count = i_count; ce_load_ack = i_ack;
        next_load = 0;
        next_valid = 0;
        if (i_ack) m_null = 0;
        if (i_cw) begin
            if (i_cwv[5:4] == 2'b00) begin
                if (!m_latched) begin
                    m_latched = 1;
                    m_snap = i_count;
                end
            end else begin
                m_rw = i_cwv[5:4]; m_mode = i_cwv[3:1]; m_bcd = i_cwv[0];
                m_prog = 1; m_rd_bytes_done = 0; m_wr_bytes_done = 0;
                m_latched = 0; m_null = 1;
            end
        end else if (m_prog && (i_wr != i_rd)) begin
            if (i_wr) begin
                m_null = 1;
                want_high = (m_rw == 2'b10) || (m_wr_bytes_done == 1);
                if (m_rw != 2'b11) m_count = 16'h0;
                if (want_high) m_count[15:8] = i_din;
                else           m_count[7:0] = i_din;
                m_wr_bytes_done++;
                if (m_wr_bytes_done == seqLen(m_rw)) begin
                    m_wr_bytes_done = 0;
                    next_load = 1;
                    load_q.push_back(m_count);
                end
            end else begin
                src = m_latched ? m_snap : i_count;
                want_high = (m_rw == 2'b10) || (m_rd_bytes_done == 1);
                b = want_high ? src[15:8] : src[7:0];
                m_rd_bytes_done++;
                if (m_rd_bytes_done == seqLen(m_rw)) begin
                    m_rd_bytes_done = 0;
                    m_latched = 0;
                end
                read_q.push_back(b);
                m_last_out = b;
                next_valid = 1;
            end
        end
        @(posedge clk);
        #1;
        cw_wr = 0; wr = 0; rd = 0; ce_load_ack = 0;
        m_load_now = next_load;
        m_valid_now = next_valid;
    endtask

    task automatic idle(input logic [15:0] i_count);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, i_count, 0);
    endtask

    task automatic checkOutput();
        checkValue("count_reg", count_reg, m_count);
        checkValue("count_load", 16'(count_load), 16'(m_load_now));
        checkValue("data_out", 16'(data_out), 16'(m_last_out));
        checkValue("data_valid", 16'(data_valid), 16'(m_valid_now));
        checkValue("rw_mode", 16'(rw_mode), 16'(m_rw));
        checkValue("mode", 16'(mode), 16'(m_mode));
        checkValue("bcd", 16'(bcd), 16'(m_bcd));
        checkValue("latched", 16'(latched), 16'(m_latched));
        checkValue("null_count", 16'(null_count), 16'(m_null));
        checkValue("programmed", 16'(programmed), 16'(m_prog));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic doReset();
        reset_n = 0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        reset_n = 1;
        checkOutput();
    endtask

    task automatic step(input bit i_cw, input logic [7:0] i_cwv, input bit i_wr, input bit i_rd,
                        input logic [7:0] i_din, input logic [15:0] i_count, input bit i_ack);
        applyStimulus(i_cw, i_cwv, i_wr, i_rd, i_din, i_count, i_ack);
        checkOutput();
    endtask

    // Scoreboard monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (data_valid) begin
                if (read_q.size() == 0) begin
                    checkValue("unexpected_data_valid", 16'(data_valid), 16'h0);
                end else begin
                    checkValue("read_byte", 16'(data_out), 16'(read_q.pop_front()));
                end
            end
            if (count_load) begin
                if (load_q.size() == 0) begin
                    checkValue("unexpected_count_load", 16'(count_load), 16'h0);
                end else begin
                    checkValue("loaded_count", count_reg, load_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0]  r_cwv;
        int          r;
        reset_n = 0; cw_wr = 0; cw = 8'h00; wr = 0; rd = 0;
        data_in = 8'h00; current_count = 16'h0; ce_load_ack = 0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] unprogrammed accesses");
        step(0, 8'h00, 0, 1, 8'h00, 16'h4321, 0);
        step(0, 8'h00, 1, 0, 8'h55, 16'h4321, 0);
        step(0, 8'h00, 0, 0, 8'h00, 16'h4321, 0);

        $display("[TB] LSB-then-MSB write");
        step(1, 8'h34, 0, 0, 8'h00, 16'h0, 0);
        step(0, 8'h00, 1, 0, 8'hCD, 16'h0, 0);
        step(0, 8'h00, 1, 0, 8'hAB, 16'h0, 0);
        step(0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
        step(0, 8'h00, 0, 0, 8'h00, 16'h0, 1);

        $display("[TB] latched two-byte read");
        step(1, 8'h00, 0, 0, 8'h00, 16'h1234, 0);
        step(0, 8'h00, 0, 1, 8'h00, 16'h1200, 0);
        step(0, 8'h00, 0, 1, 8'h00, 16'h1200, 0);
        step(0, 8'h00, 0, 1, 8'h00, 16'h1200, 0);
        step(0, 8'h00, 0, 0, 8'h00, 16'h1200, 0);

        $display("[TB] single-byte modes");
        step(1, 8'h10, 0, 0, 8'h00, 16'h5678, 0);
        step(0, 8'h00, 0, 1, 8'h00, 16'h5678, 0);
        step(1, 8'h20, 0, 0, 8'h00, 16'h5678, 0);
        step(0, 8'h00, 1, 0, 8'h9A, 16'h5678, 0);

        $display("[TB] repeated latch command");
        step(1, 8'h00, 0, 0, 8'h00, 16'h1111, 0);
        step(1, 8'h00, 0, 0, 8'h00, 16'h2222, 0);
        step(0, 8'h00, 0, 1, 8'h00, 16'h3333, 0);
        step(0, 8'h00, 0, 0, 8'h00, 16'h3333, 0);

        $display("[TB] mode word aborts partial write");
        step(1, 8'h34, 0, 0, 8'h00, 16'h0, 0);
        step(0, 8'h00, 1, 0, 8'h11, 16'h0, 0);
        step(1, 8'h34, 0, 0, 8'h00, 16'h0, 0);
        step(0, 8'h00, 1, 0, 8'h22, 16'h0, 0);
        step(0, 8'h00, 1, 0, 8'h33, 16'h0, 1);
        step(0, 8'h00, 1, 1, 8'h44, 16'h0, 0);

        $display("[TB] reset mid-read");
        step(0, 8'h00, 0, 1, 8'h00, 16'hBEEF, 0);
        idle(16'hBEEF);
        doReset();
        step(0, 8'h00, 0, 1, 8'h00, 16'hBEEF, 0);

        $display("[TB] random traffic");
        step(1, 8'h36, 0, 0, 8'h00, 16'h0, 0);
        for (int n = 0; n < 900; n++) begin
            r = $urandom_range(0, 99);
            r_cwv = 8'($urandom_range(0, 255));
            if (n % 300 == 299) begin
                idle(16'($urandom));
                doReset();
                r_cwv[5:4] = 2'($urandom_range(1, 3));
                step(1, r_cwv, 0, 0, 8'h00, 16'($urandom), 0);
            end else if (r < 5) begin
                r_cwv[5:4] = 2'($urandom_range(1, 3));
                step(1, r_cwv, 0, 0, 8'h00, 16'($urandom), $urandom_range(0, 3) == 0);
            end else if (r < 14) begin
                r_cwv[5:4] = 2'b00;
                step(1, r_cwv, 0, 0, 8'h00, 16'($urandom), $urandom_range(0, 3) == 0);
            end else if (r < 45) begin
                step(0, 8'h00, 1, 0, 8'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
            end else if (r < 82) begin
                step(0, 8'h00, 0, 1, 8'h00, 16'($urandom), $urandom_range(0, 3) == 0);
            end else if (r < 87) begin
                step(0, 8'h00, 1, 1, 8'($urandom), 16'($urandom), 0);
            end else begin
                step(0, 8'h00, 0, 0, 8'h00, 16'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        idle(16'h0);
        idle(16'h0);
        checkValue("read_queue_drained", 16'(read_q.size()), 16'h0);
        checkValue("load_queue_drained", 16'(load_q.size()), 16'h0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/counter_access_ctrl.md
Name: counter_access_ctrl

Overview:
- Per-counter CPU access sequencer for the 8254 timer. Sits between the bus interface and one 16-bit counting element.
- Decodes control words for its counter: RW mode, operating mode, BCD and the counter-latch command.
- Sequences byte-wise writes into a 16-bit count register and byte-wise reads from either the live count or a 16-bit latched snapshot.
- Owns the output-latch hold/release policy and the read/write byte flip-flops.

Parameters:
- WIDTH, 16, count width (fixed at 2 bytes; other values unsupported)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cw_wr  in  1  one-cycle strobe: control word addressed to this counter (SC already decoded upstream)
- cw  in  8  control word: [5:4] RW, [3:1] mode, [0] BCD
- wr  in  1  one-cycle strobe: data write to this counter
- rd  in  1  one-cycle strobe: data read from this counter
- data_in  in  8  CPU write byte
- current_count  in  16  live value from counting element
- ce_load_ack  in  1  counting element has taken count_reg
- count_reg  out  16  initial count register
- count_load  out  1  one-cycle pulse: count_reg complete and valid
- data_out  out  8  read byte, registered
- data_valid  out  1  one-cycle pulse qualifying data_out
- rw_mode  out  2  current RW mode (01 LSB, 10 MSB, 11 LSB-then-MSB)
- mode  out  3  operating mode field
- bcd  out  1  BCD flag
- latched  out  1  output latch holding a snapshot
- null_count  out  1  count written but not yet taken by the counting element
- programmed  out  1  at least one mode control word received

Behaviour:
- Reset (async, reset_n=0):
  - count_reg=0, count_load=0, data_out=0, data_valid=0, rw_mode=01, mode=0, bcd=0.
  - latched=0, null_count=0, programmed=0, snapshot=0, read_ff=0, write_ff=0.
- Reset mid-operation aborts any partial byte sequence.
- Until programmed=1, rd and wr are ignored: no data_valid, no state change.
- Priority per cycle: cw_wr > (rd, wr). rd and wr asserted together in the same cycle: both ignored.
- cw_wr with cw[5:4]=00 (latch command):
  - If latched=0: snapshot<=current_count and latched<=1.
  - If latched=1: ignored; first snapshot kept.
  - Mode, flip-flops and count_reg unchanged.
- cw_wr with cw[5:4]!=00 (mode word):
  - rw_mode<=cw[5:4], mode<=cw[3:1], bcd<=cw[0], programmed<=1.
  - read_ff<=0, write_ff<=0, latched<=0, null_count<=1. count_reg unchanged.
- Write, by rw_mode:
  - 01: count_reg<={8'h00, data_in}; count_load pulses next cycle.
  - 10: count_reg<={data_in, 8'h00}; count_load pulses next cycle.
  - 11, write_ff=0: count_reg[7:0]<=data_in, write_ff<=1, no count_load.
  - 11, write_ff=1: count_reg[15:8]<=data_in, write_ff<=0, count_load pulses next cycle.
- Every accepted wr sets null_count=1. ce_load_ack clears it. Same-cycle wr and ce_load_ack: null_count=1.
- Read source: snapshot if latched=1, else current_count sampled in the rd cycle.
- Read, by rw_mode:
  - 01: returns low byte.
  - 10: returns high byte.
  - 11: read_ff=0 returns low byte and read_ff<=1; read_ff=1 returns high byte and read_ff<=0.
- Read latency: data_out/data_valid registered one cycle after rd. data_out holds its value when data_valid=0.
- Latch release: after the final byte of a read sequence (01/10: every read; 11: the high-byte read), latched<=0.
- A latch command arriving between the low and high byte of a mode-11 read:
  - Takes a new snapshot (latched was 0).
  - read_ff is unchanged, so the next read returns the new snapshot's high byte.
- count_load is never asserted in the same cycle as the byte that completes the count; it always follows one cycle later.

Test Plan:
- Reset, rd and wr with no control word -> no data_valid, programmed=0, count_reg=0.
- cw=0x34 (RW=11, mode 2), wr 0xCD then wr 0xAB -> count_reg=0xABCD, a single count_load pulse after the second wr, null_count=1; ce_load_ack -> null_count=0.
- RW=11 programmed, current_count=0x1234, latch command, current_count changes to 0x1200, rd, rd -> data_out 0x34 then 0x12, latched=0 after the second read; a third rd returns the live low byte.
- cw=0x10 (RW=01), current_count=0x5678, rd -> data_out=0x78 one cycle later; cw=0x20 (RW=10), wr 0x9A -> count_reg=0x9A00.
- Two latch commands with current_count 0x1111 then 0x2222, RW=10 read -> 0x11 (second latch ignored).
- Mid-sequence events:
  - Mode word after one LSB write -> write_ff reset; next wr treated as LSB.
  - reset_n low for 1 cycle mid-read -> all outputs at their reset values immediately.
